// File: rtl/tl_async_pkg.sv
// -----------------------------------------------------------------------------
// tl_async_pkg
// Shared types and defaults for the TileLink async crossing sink.
//   - tl_a_opcode_e / tl_d_opcode_e : TileLink opcodes this crossing carries
//   - DEF_ADDR_W / DEF_DATA_W / DEF_SYNC_STAGES : default parameter values
//   - a_state_e : A-side holding register occupancy (EMPTY / FULL)
// -----------------------------------------------------------------------------
package tl_async_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } tl_a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } a_state_e;

endpackage

// File: rtl/tl_async_crossing_sink_sync.sv
// -----------------------------------------------------------------------------
// async_bit_sync
// N-stage single-bit synchronizer for signals arriving from the remote clock
// domain. All stages clear to 0 on the asynchronous active-low reset.
//   clock : local clock
//   reset : asynchronous active-low reset
//   d     : asynchronous input from the remote domain
//   q     : synchronized output (N edges of latency)
// -----------------------------------------------------------------------------
module async_bit_sync #(
  parameter int N = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift the remote bit one stage further into the local domain.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // Synchronizer stage flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/tl_async_crossing_sink.sv
// -----------------------------------------------------------------------------
// tl_async_crossing_sink
// Slave-domain half of a TileLink async crossing.
//   A channel: drains the single-entry async queue (a_mem_0, 1-bit Gray
//              indices) into a registered TileLink A request (out_a_*).
//   D channel: acts as the queue source, writing accepted TileLink D beats
//              into d_mem_0 and advancing d_widx.
// Ports:
//   clock, reset (async, active low)
//   a_mem_0_*, a_widx, a_safe_widx_valid, a_safe_source_reset_n : from remote
//   a_ridx, a_safe_ridx_valid, a_safe_sink_reset_n               : to remote
//   out_a_valid/ready/opcode/address/data                        : TL A out
//   in_d_valid/ready/opcode/size/source/data                     : TL D in
//   d_mem_0_*, d_widx, d_safe_widx_valid, d_safe_source_reset_n  : to remote
//   d_ridx, d_safe_ridx_valid, d_safe_sink_reset_n               : from remote
// Build option: define TL_ASYNC_SINK_ASSERT_EN to bind in the SVA checker.
// -----------------------------------------------------------------------------
module tl_async_crossing_sink
  import tl_async_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        a_mem_0_opcode,
  input  logic [ADDR_W-1:0] a_mem_0_address,
  input  logic [DATA_W-1:0] a_mem_0_data,
  input  logic              a_widx,
  output logic              a_ridx,
  input  logic              a_safe_widx_valid,
  input  logic              a_safe_source_reset_n,
  output logic              a_safe_ridx_valid,
  output logic              a_safe_sink_reset_n,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [2:0]        out_a_opcode,
  output logic [ADDR_W-1:0] out_a_address,
  output logic [DATA_W-1:0] out_a_data,
  input  logic              in_d_valid,
  output logic              in_d_ready,
  input  logic [2:0]        in_d_opcode,
  input  logic [1:0]        in_d_size,
  input  logic              in_d_source,
  input  logic [DATA_W-1:0] in_d_data,
  output logic [2:0]        d_mem_0_opcode,
  output logic [1:0]        d_mem_0_size,
  output logic              d_mem_0_source,
  output logic [DATA_W-1:0] d_mem_0_data,
  output logic              d_widx,
  input  logic              d_ridx,
  output logic              d_safe_widx_valid,
  output logic              d_safe_source_reset_n,
  input  logic              d_safe_ridx_valid,
  input  logic              d_safe_sink_reset_n
);

  // ---- synchronized remote signals ----
  logic a_widx_sync_s, a_widx_valid_s, a_src_rst_n_s;
  logic d_ridx_s, d_ridx_valid_s, d_snk_rst_n_s;

  async_bit_sync #(.N(SYNC_STAGES)) u_sync_a_widx  (.clock(clock), .reset(reset), .d(a_widx),                .q(a_widx_sync_s));
  async_bit_sync #(.N(SYNC_STAGES)) u_sync_a_wval  (.clock(clock), .reset(reset), .d(a_safe_widx_valid),     .q(a_widx_valid_s));
  async_bit_sync #(.N(SYNC_STAGES)) u_sync_a_srst  (.clock(clock), .reset(reset), .d(a_safe_source_reset_n), .q(a_src_rst_n_s));
  async_bit_sync #(.N(SYNC_STAGES)) u_sync_d_ridx  (.clock(clock), .reset(reset), .d(d_ridx),                .q(d_ridx_s));
  async_bit_sync #(.N(SYNC_STAGES)) u_sync_d_rval  (.clock(clock), .reset(reset), .d(d_safe_ridx_valid),     .q(d_ridx_valid_s));
  async_bit_sync #(.N(SYNC_STAGES)) u_sync_d_srst  (.clock(clock), .reset(reset), .d(d_safe_sink_reset_n),   .q(d_snk_rst_n_s));

  // ---- local liveness flops: 0 in reset, 1 from the first edge after ----
  logic a_ridx_valid_q, a_sink_rst_n_q, d_widx_valid_q, d_src_rst_n_q;

  // Local liveness / reset-status indicators.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_ridx_valid_q <= 1'b0;
      a_sink_rst_n_q <= 1'b0;
      d_widx_valid_q <= 1'b0;
      d_src_rst_n_q  <= 1'b0;
    end else begin
      a_ridx_valid_q <= 1'b1;
      a_sink_rst_n_q <= 1'b1;
      d_widx_valid_q <= 1'b1;
      d_src_rst_n_q  <= 1'b1;
    end
  end

  // ---- A side ----
  a_state_e          state_q, state_d;
  logic              a_ridx_q, a_ridx_d;
  logic [2:0]        a_opcode_q, a_opcode_d;
  logic [ADDR_W-1:0] a_address_q, a_address_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              a_live_s;
  logic              a_widx_s;

  // The remote side is only trusted while it reports itself valid and out of
  // reset; otherwise its write index is treated as 0.
  assign a_live_s = a_widx_valid_s & a_src_rst_n_s;
  assign a_widx_s = a_widx_sync_s & a_live_s;

  // A-side next state: capture a new queue entry, or retire on handshake.
  always_comb begin
    state_d     = state_q;
    a_ridx_d    = a_ridx_q;
    a_opcode_d  = a_opcode_q;
    a_address_d = a_address_q;
    a_data_d    = a_data_q;
    if (!a_live_s) begin
      // Remote reset drops any pending beat, even one mid-handshake.
      state_d  = ST_EMPTY;
      a_ridx_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (a_widx_s != a_ridx_q) begin
            state_d     = ST_FULL;
            a_ridx_d    = ~a_ridx_q;   // frees the remote slot immediately
            a_opcode_d  = a_mem_0_opcode;
            a_address_d = a_mem_0_address;
            a_data_d    = a_mem_0_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_a_ready) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          a_ridx_d = 1'b0;
        end
      endcase
    end
  end

  // A-side state, read index and holding register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      a_ridx_q    <= 1'b0;
      a_opcode_q  <= 3'd0;
      a_address_q <= '0;
      a_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_ridx_q    <= a_ridx_d;
      a_opcode_q  <= a_opcode_d;
      a_address_q <= a_address_d;
      a_data_q    <= a_data_d;
    end
  end

  // Gating with liveness lets a remote reset be seen as soon as it is
  // synchronized, one edge before the state register itself clears.
  assign out_a_valid         = (state_q == ST_FULL) & a_live_s;
  assign a_ridx              = a_ridx_q & a_live_s;
  assign out_a_opcode        = a_opcode_q;
  assign out_a_address       = a_address_q;
  assign out_a_data          = a_data_q;
  assign a_safe_ridx_valid   = a_ridx_valid_q;
  assign a_safe_sink_reset_n = a_sink_rst_n_q;

  // ---- D side ----
  logic              d_widx_q, d_widx_d;
  logic [2:0]        d_opcode_q, d_opcode_d;
  logic [1:0]        d_size_q, d_size_d;
  logic              d_source_q, d_source_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              d_live_s;
  logic              d_fire_s;

  assign d_live_s   = d_ridx_valid_s & d_snk_rst_n_s & d_widx_valid_q;
  // Slot is free only when the remote reader has caught up with our write index.
  assign in_d_ready = d_live_s & (d_widx_q == d_ridx_s);
  assign d_fire_s   = in_d_valid & in_d_ready;

  // D-side next state: write the queue slot and advance the write index.
  always_comb begin
    d_widx_d   = d_widx_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    if (!d_live_s) begin
      d_widx_d = 1'b0;              // slot contents are kept
    end else if (d_fire_s) begin
      d_widx_d   = ~d_widx_q;
      d_opcode_d = in_d_opcode;
      d_size_d   = in_d_size;
      d_source_d = in_d_source;
      d_data_d   = in_d_data;
    end else begin
      d_widx_d = d_widx_q;
    end
  end

  // D-side write index and queue slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_widx_q   <= 1'b0;
      d_opcode_q <= 3'd0;
      d_size_q   <= 2'd0;
      d_source_q <= 1'b0;
      d_data_q   <= '0;
    end else begin
      d_widx_q   <= d_widx_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
    end
  end

  assign d_widx                = d_widx_q;
  assign d_mem_0_opcode        = d_opcode_q;
  assign d_mem_0_size          = d_size_q;
  assign d_mem_0_source        = d_source_q;
  assign d_mem_0_data          = d_data_q;
  assign d_safe_widx_valid     = d_widx_valid_q;
  assign d_safe_source_reset_n = d_src_rst_n_q;

`ifdef TL_ASYNC_SINK_ASSERT_EN
  tl_async_crossing_sink_chk #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
    .clock        (clock),
    .reset        (reset),
    .state_full   (state_q == ST_FULL),
    .a_widx_s     (a_widx_s),
    .out_a_valid  (out_a_valid),
    .out_a_ready  (out_a_ready),
    .out_a_opcode (out_a_opcode),
    .out_a_address(out_a_address),
    .out_a_data   (out_a_data),
    .d_fire       (d_fire_s),
    .in_d_opcode  (in_d_opcode),
    .in_d_size    (in_d_size),
    .in_d_source  (in_d_source),
    .in_d_data    (in_d_data)
  );
`endif

endmodule

`ifdef TL_ASYNC_SINK_ASSERT_EN
// Protocol checker for tl_async_crossing_sink (simulation only).
module tl_async_crossing_sink_chk
  import tl_async_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic              clock,
  input logic              reset,
  input logic              state_full,
  input logic              a_widx_s,
  input logic              out_a_valid,
  input logic              out_a_ready,
  input logic [2:0]        out_a_opcode,
  input logic [ADDR_W-1:0] out_a_address,
  input logic [DATA_W-1:0] out_a_data,
  input logic              d_fire,
  input logic [2:0]        in_d_opcode,
  input logic [1:0]        in_d_size,
  input logic              in_d_source,
  input logic [DATA_W-1:0] in_d_data
);
  a_stable: assert property (@(posedge clock) disable iff (!reset)
    (out_a_valid && !out_a_ready) ##1 out_a_valid |->
      $stable({out_a_opcode, out_a_address, out_a_data}));
  a_opcode: assert property (@(posedge clock) disable iff (!reset)
    out_a_valid |-> (out_a_opcode inside {A_PUT_FULL_DATA, A_PUT_PARTIAL_DATA, A_GET}));
  a_widx_empty: assert property (@(posedge clock) disable iff (!reset)
    ($changed(a_widx_s) && a_widx_s != 1'b0) |-> !state_full);
  d_legal: assert property (@(posedge clock) disable iff (!reset)
    d_fire |-> (!$isunknown({in_d_opcode, in_d_size, in_d_source, in_d_data}) &&
                (in_d_opcode inside {D_ACCESS_ACK, D_ACCESS_ACK_DATA})));
endmodule
`endif

// File: tb/tb_tl_async_crossing_sink.sv
module tb_tl_async_crossing_sink;
  localparam int SS = 3;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    a_mem_0_opcode;
  logic [AW-1:0] a_mem_0_address;
  logic [DW-1:0] a_mem_0_data;
  logic          a_widx, a_ridx;
  logic          a_safe_widx_valid, a_safe_source_reset_n;
  logic          a_safe_ridx_valid, a_safe_sink_reset_n;
  logic          out_a_valid, out_a_ready;
  logic [2:0]    out_a_opcode;
  logic [AW-1:0] out_a_address;
  logic [DW-1:0] out_a_data;
  logic          in_d_valid, in_d_ready;
  logic [2:0]    in_d_opcode;
  logic [1:0]    in_d_size;
  logic          in_d_source;
  logic [DW-1:0] in_d_data;
  logic [2:0]    d_mem_0_opcode;
  logic [1:0]    d_mem_0_size;
  logic          d_mem_0_source;
  logic [DW-1:0] d_mem_0_data;
  logic          d_widx, d_ridx;
  logic          d_safe_widx_valid, d_safe_source_reset_n;
  logic          d_safe_ridx_valid, d_safe_sink_reset_n;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tl_async_crossing_sink #(.SYNC_STAGES(SS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .a_mem_0_opcode(a_mem_0_opcode), .a_mem_0_address(a_mem_0_address), .a_mem_0_data(a_mem_0_data),
    .a_widx(a_widx), .a_ridx(a_ridx),
    .a_safe_widx_valid(a_safe_widx_valid), .a_safe_source_reset_n(a_safe_source_reset_n),
    .a_safe_ridx_valid(a_safe_ridx_valid), .a_safe_sink_reset_n(a_safe_sink_reset_n),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_opcode(out_a_opcode), .out_a_address(out_a_address), .out_a_data(out_a_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_opcode(in_d_opcode), .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data),
    .d_mem_0_opcode(d_mem_0_opcode), .d_mem_0_size(d_mem_0_size),
    .d_mem_0_source(d_mem_0_source), .d_mem_0_data(d_mem_0_data),
    .d_widx(d_widx), .d_ridx(d_ridx),
    .d_safe_widx_valid(d_safe_widx_valid), .d_safe_source_reset_n(d_safe_source_reset_n),
    .d_safe_ridx_valid(d_safe_ridx_valid), .d_safe_sink_reset_n(d_safe_sink_reset_n)
  );

  // Advance one rising edge, then settle before driving or sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_mem_0_opcode = 3'd0; a_mem_0_address = '0; a_mem_0_data = '0;
    a_widx = 1'b0; a_safe_widx_valid = 1'b0; a_safe_source_reset_n = 1'b0;
    out_a_ready = 1'b0;
    in_d_valid = 1'b0; in_d_opcode = 3'd0; in_d_size = 2'd0; in_d_source = 1'b0; in_d_data = '0;
    d_ridx = 1'b0; d_safe_ridx_valid = 1'b0; d_safe_sink_reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out_a_valid, a_ridx, d_widx, in_d_ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0000", {out_a_valid, a_ridx, d_widx, in_d_ready});
    end
    checks++;
    if ({a_safe_ridx_valid, a_safe_sink_reset_n, d_safe_widx_valid, d_safe_source_reset_n} !== 4'b0000) begin
      failures++; $display("FAIL reset_safe got=%b exp=0000",
        {a_safe_ridx_valid, a_safe_sink_reset_n, d_safe_widx_valid, d_safe_source_reset_n});
    end
    checks++;
    if ({out_a_opcode, out_a_address, out_a_data} !== 44'd0) begin
      failures++; $display("FAIL reset_out_a got=%h exp=0", {out_a_opcode, out_a_address, out_a_data});
    end
    checks++;
    if ({d_mem_0_opcode, d_mem_0_size, d_mem_0_source, d_mem_0_data} !== 38'd0) begin
      failures++; $display("FAIL reset_d_mem got=%h exp=0", {d_mem_0_opcode, d_mem_0_size, d_mem_0_source, d_mem_0_data});
    end
    // Release reset between edges with the remote side already live.
    @(negedge clock);
    reset = 1'b1;
    a_safe_widx_valid = 1'b1; a_safe_source_reset_n = 1'b1;
    d_safe_ridx_valid = 1'b1; d_safe_sink_reset_n = 1'b1;
    tick();
    checks++;
    if ({a_safe_ridx_valid, a_safe_sink_reset_n, d_safe_widx_valid, d_safe_source_reset_n} !== 4'b1111) begin
      failures++; $display("FAIL release_safe got=%b exp=1111",
        {a_safe_ridx_valid, a_safe_sink_reset_n, d_safe_widx_valid, d_safe_source_reset_n});
    end
    for (int e = 1; e <= SS; e++) begin
      if (e > 1) tick();
      checks++;
      if (in_d_ready !== (e == SS)) begin
        failures++; $display("FAIL release_d_ready edge=%0d got=%b exp=%b", e, in_d_ready, (e == SS));
      end
    end
  endtask

  task automatic test_a_beat();
    a_mem_0_opcode = 3'd4; a_mem_0_address = 9'h1F0; a_mem_0_data = 32'hDEADBEEF;
    a_widx = 1'b1;
    for (int e = 1; e <= SS + 1; e++) begin
      tick();
      checks++;
      if ({out_a_valid, a_ridx} !== ((e == SS + 1) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL a_beat_latency edge=%0d got=%b exp=%b", e, {out_a_valid, a_ridx},
          ((e == SS + 1) ? 2'b11 : 2'b00));
      end
    end
    checks++;
    if ({out_a_opcode, out_a_address, out_a_data} !== {3'd4, 9'h1F0, 32'hDEADBEEF}) begin
      failures++; $display("FAIL a_beat_fields got=%h exp=%h", {out_a_opcode, out_a_address, out_a_data},
        {3'd4, 9'h1F0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_backpressure();
    // Remote slot contents change; the holding register must not follow.
    a_mem_0_opcode = 3'd1; a_mem_0_address = 9'h0AA; a_mem_0_data = 32'h0BADF00D;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({out_a_valid, out_a_opcode, out_a_address, out_a_data} !== {1'b1, 3'd4, 9'h1F0, 32'hDEADBEEF}) begin
        failures++; $display("FAIL backpressure_hold cycle=%0d got=%h", c,
          {out_a_valid, out_a_opcode, out_a_address, out_a_data});
      end
    end
    out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
    checks++;
    if (out_a_valid !== 1'b0) begin
      failures++; $display("FAIL backpressure_accept got=%b exp=0", out_a_valid);
    end
    repeat (4) tick();
    checks++;
    if ({out_a_valid, a_ridx} !== 2'b01) begin
      failures++; $display("FAIL backpressure_no_recapture got=%b exp=01", {out_a_valid, a_ridx});
    end
  endtask

  task automatic test_ready_high();
    a_mem_0_opcode = 3'd0; a_mem_0_address = 9'h005; a_mem_0_data = 32'hA5A50001;
    out_a_ready = 1'b1;
    a_widx = 1'b0;
    repeat (SS + 1) tick();
    checks++;
    if ({out_a_valid, a_ridx, out_a_opcode, out_a_address, out_a_data} !== {2'b10, 3'd0, 9'h005, 32'hA5A50001}) begin
      failures++; $display("FAIL ready_high_capture got=%h", {out_a_valid, a_ridx, out_a_opcode, out_a_address, out_a_data});
    end
    tick();
    checks++;
    if (out_a_valid !== 1'b0) begin
      failures++; $display("FAIL ready_high_single_cycle got=%b exp=0", out_a_valid);
    end
    out_a_ready = 1'b0;
  endtask

  task automatic test_d_beat();
    checks++;
    if (in_d_ready !== 1'b1) begin
      failures++; $display("FAIL d_ready_initial got=%b exp=1", in_d_ready);
    end
    in_d_valid = 1'b1; in_d_opcode = 3'd1; in_d_size = 2'd2; in_d_source = 1'b1; in_d_data = 32'h12345678;
    tick();
    in_d_valid = 1'b0; in_d_opcode = 3'd0; in_d_data = 32'hFFFFFFFF;
    checks++;
    if ({d_mem_0_opcode, d_mem_0_size, d_mem_0_source, d_mem_0_data, d_widx} !== {3'd1, 2'd2, 1'b1, 32'h12345678, 1'b1}) begin
      failures++; $display("FAIL d_beat_mem got=%h", {d_mem_0_opcode, d_mem_0_size, d_mem_0_source, d_mem_0_data, d_widx});
    end
    checks++;
    if (in_d_ready !== 1'b0) begin
      failures++; $display("FAIL d_beat_ready_drop got=%b exp=0", in_d_ready);
    end
    d_ridx = 1'b1;
    for (int e = 1; e <= SS; e++) begin
      tick();
      checks++;
      if (in_d_ready !== (e == SS)) begin
        failures++; $display("FAIL d_ready_return edge=%0d got=%b exp=%b", e, in_d_ready, (e == SS));
      end
    end
    checks++;
    if (d_mem_0_data !== 32'h12345678) begin
      failures++; $display("FAIL d_mem_stable got=%h exp=12345678", d_mem_0_data);
    end
  endtask

  task automatic test_remote_reset();
    a_mem_0_opcode = 3'd1; a_mem_0_address = 9'h100; a_mem_0_data = 32'h00C0FFEE;
    a_widx = 1'b1;
    repeat (SS + 1) tick();
    checks++;
    if ({out_a_valid, a_ridx} !== 2'b11) begin
      failures++; $display("FAIL remote_reset_full got=%b exp=11", {out_a_valid, a_ridx});
    end
    a_safe_source_reset_n = 1'b0;
    a_widx = 1'b0;
    for (int e = 1; e <= SS; e++) begin
      tick();
      checks++;
      if ({out_a_valid, a_ridx} !== ((e == SS) ? 2'b00 : 2'b11)) begin
        failures++; $display("FAIL remote_reset_drop edge=%0d got=%b exp=%b", e, {out_a_valid, a_ridx},
          ((e == SS) ? 2'b00 : 2'b11));
      end
    end
    a_safe_source_reset_n = 1'b1;
    repeat (SS + 3) tick();
    checks++;
    if ({out_a_valid, a_ridx} !== 2'b00) begin
      failures++; $display("FAIL remote_reset_recover got=%b exp=00", {out_a_valid, a_ridx});
    end
  endtask

  task automatic test_local_reset();
    in_d_valid = 1'b1; in_d_opcode = 3'd0; in_d_size = 2'd1; in_d_source = 1'b0; in_d_data = 32'h55AA55AA;
    checks++;
    if (in_d_ready !== 1'b1) begin
      failures++; $display("FAIL local_reset_pre_ready got=%b exp=1", in_d_ready);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_a_valid, a_ridx, d_widx, in_d_ready, a_safe_ridx_valid, a_safe_sink_reset_n,
         d_safe_widx_valid, d_safe_source_reset_n} !== 8'd0) begin
      failures++; $display("FAIL local_reset_ctl got=%b exp=00000000", {out_a_valid, a_ridx, d_widx, in_d_ready,
        a_safe_ridx_valid, a_safe_sink_reset_n, d_safe_widx_valid, d_safe_source_reset_n});
    end
    checks++;
    if ({d_mem_0_opcode, d_mem_0_size, d_mem_0_source, d_mem_0_data, out_a_opcode, out_a_address, out_a_data} !== 82'd0) begin
      failures++; $display("FAIL local_reset_data got=%h exp=0",
        {d_mem_0_opcode, d_mem_0_size, d_mem_0_source, d_mem_0_data, out_a_opcode, out_a_address, out_a_data});
    end
    tick();
    checks++;
    if ({d_widx, in_d_ready, d_mem_0_data} !== 34'd0) begin
      failures++; $display("FAIL local_reset_held got=%h exp=0", {d_widx, in_d_ready, d_mem_0_data});
    end
    in_d_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_beat();
    test_backpressure();
    test_ready_high();
    test_d_beat();
    test_remote_reset();
    test_local_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
